// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-captured pending bits, CSR-programmable enables,
// fixed highest-index-wins priority and a non-nesting IDLE/REQ/SERVICE handshake.
module irq_arbiter #(
    parameter int N    = 64,
    parameter int NSRC = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MIE,
    input  logic [NSRC-1:0] irqSrc,
    input  logic            syncExcept,
    input  logic            trapAck,
    input  logic            mret,
    input  logic [11:0]     CSR_addr,
    input  logic [N-1:0]    CSR_In,
    input  logic            CSR_WriteEnable,
    output logic [15:0]     interruptSignal,
    output logic            async,
    output logic [N-1:0]    mip,
    output logic [N-1:0]    mie,
    output logic            busy,
    output logic [1:0]      fsm_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    localparam logic [11:0] ADDR_MIE = 12'h304;
    localparam logic [11:0] ADDR_MIP = 12'h344;

    logic [1:0]      state;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] irq_prev;
    logic [3:0]      grant_idx;

    logic [NSRC-1:0] edges;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] clear_mask;
    logic [NSRC-1:0] pending_next;
    logic [3:0]      win_idx;
    logic [15:0]     win_onehot;
    logic            csr_mie_wr;
    logic            csr_mip_wr;
    logic            unused_bits;

    assign edges      = irqSrc & ~irq_prev;
    assign eligible   = pending & enable;
    assign csr_mie_wr = CSR_WriteEnable && (CSR_addr == ADDR_MIE);
    assign csr_mip_wr = CSR_WriteEnable && (CSR_addr == ADDR_MIP);
    assign unused_bits = ^CSR_In;

    // Later iterations overwrite earlier ones, so the highest eligible index wins.
    always_comb begin
        win_idx = 4'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (eligible[i]) win_idx = 4'(i);
        end
    end

    assign win_onehot = 16'd1 << win_idx;

    // Clears (CSR write-0 and trap acknowledge) are applied first; new edges are
    // OR-ed in afterwards so a same-cycle set always survives.
    always_comb begin
        clear_mask = '1;
        if (csr_mip_wr) clear_mask = CSR_In[NSRC-1:0];
        if (state == REQ && trapAck) clear_mask = clear_mask & ~(NSRC'(1) << grant_idx);
    end

    assign pending_next = (pending & clear_mask) | edges;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            pending         <= '0;
            enable          <= '0;
            irq_prev        <= '0;
            grant_idx       <= 4'd0;
            interruptSignal <= 16'd0;
            async           <= 1'b0;
        end else begin
            irq_prev <= irqSrc;
            pending  <= pending_next;
            if (csr_mie_wr) enable <= CSR_In[NSRC-1:0];

            case (state)
                IDLE: begin
                    if (MIE && (|eligible) && !syncExcept) begin
                        state           <= REQ;
                        grant_idx       <= win_idx;
                        interruptSignal <= win_onehot;
                        async           <= 1'b1;
                    end
                end
                REQ: begin
                    // trapAck has precedence over an abort in the same cycle.
                    if (trapAck) begin
                        state           <= SERVICE;
                        interruptSignal <= 16'd0;
                        async           <= 1'b0;
                    end else if (syncExcept || !MIE) begin
                        state           <= IDLE;
                        interruptSignal <= 16'd0;
                        async           <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (mret) state <= IDLE;
                end
                default: begin
                    state           <= IDLE;
                    interruptSignal <= 16'd0;
                    async           <= 1'b0;
                end
            endcase
        end
    end

    assign mip       = N'(pending);
    assign mie       = N'(enable);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: each task drives one scenario and checks
// outputs against hand-computed values, then a single summary line is printed.
module tb_irq_arbiter;

    localparam int N    = 64;
    localparam int NSRC = 16;

    logic            clk;
    logic            reset;
    logic            MIE;
    logic [NSRC-1:0] irqSrc;
    logic            syncExcept;
    logic            trapAck;
    logic            mret;
    logic [11:0]     CSR_addr;
    logic [N-1:0]    CSR_In;
    logic            CSR_WriteEnable;
    logic [15:0]     interruptSignal;
    logic            async;
    logic [N-1:0]    mip;
    logic [N-1:0]    mie;
    logic            busy;
    logic [1:0]      fsm_state;

    int vectors;
    int miscompares;

    irq_arbiter #(.N(N), .NSRC(NSRC)) dut (
        .clk             (clk),
        .reset           (reset),
        .MIE             (MIE),
        .irqSrc          (irqSrc),
        .syncExcept      (syncExcept),
        .trapAck         (trapAck),
        .mret            (mret),
        .CSR_addr        (CSR_addr),
        .CSR_In          (CSR_In),
        .CSR_WriteEnable (CSR_WriteEnable),
        .interruptSignal (interruptSignal),
        .async           (async),
        .mip             (mip),
        .mie             (mie),
        .busy            (busy),
        .fsm_state       (fsm_state)
    );

    // Clock and time limit
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [N-1:0] data);
        CSR_addr        = addr;
        CSR_In          = data;
        CSR_WriteEnable = 1'b1;
        tick();
        CSR_WriteEnable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if (interruptSignal !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_irq: got %h want 0000", interruptSignal);
        end
        vectors++;
        if (async !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: async=%b busy=%b want 0 0", async, busy);
        end
        vectors++;
        if (mip !== 64'h0 || mie !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_csr: mip=%h mie=%h want 0 0", mip, mie);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        csr_write(12'h304, 64'h1);
        vectors++;
        if (mie !== 64'h1) begin
            miscompares++;
            $display("FAIL basic_mie: got %h want 1", mie);
        end
        MIE       = 1'b1;
        irqSrc[0] = 1'b1;
        tick();
        irqSrc = '0;
        vectors++;
        if (mip !== 64'h1 || interruptSignal !== 16'h0000) begin
            miscompares++;
            $display("FAIL basic_pending: mip=%h irq=%h want 1 0000", mip, interruptSignal);
        end
        tick();
        vectors++;
        if (interruptSignal !== 16'h0001 || async !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_grant: irq=%h async=%b busy=%b want 0001 1 1", interruptSignal, async, busy);
        end
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;
        vectors++;
        if (fsm_state !== 2'd2 || mip !== 64'h0 || interruptSignal !== 16'h0 || async !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_service: state=%0d mip=%h irq=%h async=%b want 2 0 0 0",
                     fsm_state, mip, interruptSignal, async);
        end
        mret = 1'b1;
        tick();
        mret = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_mret: busy=%b want 0", busy);
        end
    endtask

    task automatic test_priority();
        csr_write(12'h304, 64'hFFFF);
        irqSrc = 16'h0208;
        tick();
        irqSrc = '0;
        tick();
        vectors++;
        if (interruptSignal !== 16'h0200 || mip !== 64'h0208) begin
            miscompares++;
            $display("FAIL prio_first: irq=%h mip=%h want 0200 0208", interruptSignal, mip);
        end
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;
        tick();
        vectors++;
        if (fsm_state !== 2'd2 || interruptSignal !== 16'h0 || mip !== 64'h0008) begin
            miscompares++;
            $display("FAIL prio_no_nest: state=%0d irq=%h mip=%h want 2 0000 0008", fsm_state, interruptSignal, mip);
        end
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();
        vectors++;
        if (interruptSignal !== 16'h0008 || async !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_second: irq=%h async=%b want 0008 1", interruptSignal, async);
        end
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;
        mret    = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic test_no_rearb();
        irqSrc = 16'h0004;
        tick();
        irqSrc = '0;
        tick();
        irqSrc = 16'h8000;
        tick();
        irqSrc = '0;
        tick();
        vectors++;
        if (interruptSignal !== 16'h0004 || mip !== 64'h8004) begin
            miscompares++;
            $display("FAIL norearb_hold: irq=%h mip=%h want 0004 8004", interruptSignal, mip);
        end
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;
        vectors++;
        if (mip !== 64'h8000) begin
            miscompares++;
            $display("FAIL norearb_ack: mip=%h want 8000", mip);
        end
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();
        vectors++;
        if (interruptSignal !== 16'h8000) begin
            miscompares++;
            $display("FAIL norearb_next: irq=%h want 8000", interruptSignal);
        end
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;
        mret    = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic test_sync_abort();
        irqSrc = 16'h0020;
        tick();
        irqSrc = '0;
        tick();
        syncExcept = 1'b1;
        tick();
        vectors++;
        if (interruptSignal !== 16'h0 || async !== 1'b0 || busy !== 1'b0 || mip !== 64'h0020) begin
            miscompares++;
            $display("FAIL abort_sync: irq=%h async=%b busy=%b mip=%h want 0000 0 0 0020",
                     interruptSignal, async, busy, mip);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_blocked: busy=%b want 0", busy);
        end
        syncExcept = 1'b0;
        tick();
        vectors++;
        if (interruptSignal !== 16'h0020) begin
            miscompares++;
            $display("FAIL abort_retry: irq=%h want 0020", interruptSignal);
        end
        MIE = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || interruptSignal !== 16'h0) begin
            miscompares++;
            $display("FAIL abort_mie: busy=%b irq=%h want 0 0000", busy, interruptSignal);
        end
        MIE = 1'b1;
        tick();
        trapAck    = 1'b1;
        syncExcept = 1'b1;
        tick();
        trapAck    = 1'b0;
        syncExcept = 1'b0;
        vectors++;
        if (fsm_state !== 2'd2 || mip !== 64'h0) begin
            miscompares++;
            $display("FAIL abort_ack_wins: state=%0d mip=%h want 2 0", fsm_state, mip);
        end
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic test_ignored();
        trapAck = 1'b1;
        mret    = 1'b1;
        tick();
        trapAck = 1'b0;
        mret    = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_idle: busy=%b want 0", busy);
        end
        irqSrc = 16'h0040;
        tick();
        irqSrc = '0;
        tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        vectors++;
        if (fsm_state !== 2'd1 || interruptSignal !== 16'h0040) begin
            miscompares++;
            $display("FAIL ign_mret_req: state=%0d irq=%h want 1 0040", fsm_state, interruptSignal);
        end
        trapAck = 1'b1;
        tick();
        tick();
        trapAck = 1'b0;
        vectors++;
        if (fsm_state !== 2'd2 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ign_ack_service: state=%0d busy=%b want 2 1", fsm_state, busy);
        end
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic test_set_wins();
        csr_write(12'h304, 64'h0);
        irqSrc = 16'h0030;
        tick();
        irqSrc = '0;
        tick();
        vectors++;
        if (mip !== 64'h0030) begin
            miscompares++;
            $display("FAIL setw_setup: mip=%h want 0030", mip);
        end
        irqSrc = 16'h0010;
        csr_write(12'h344, 64'hFFEF);
        irqSrc = '0;
        vectors++;
        if (mip !== 64'h0030) begin
            miscompares++;
            $display("FAIL setw_csr: mip=%h want 0030", mip);
        end
        csr_write(12'h344, 64'hFFDF);
        vectors++;
        if (mip !== 64'h0010) begin
            miscompares++;
            $display("FAIL setw_w0c: mip=%h want 0010", mip);
        end
        csr_write(12'h344, 64'hFFFF_FFFF_FFFF_0000);
        vectors++;
        if (mip !== 64'h0) begin
            miscompares++;
            $display("FAIL setw_upper_mip: mip=%h want 0", mip);
        end
        csr_write(12'h304, 64'hABCD_0000_0000_0003);
        csr_write(12'h300, 64'hFFFF);
        vectors++;
        if (mie !== 64'h3) begin
            miscompares++;
            $display("FAIL setw_upper_mie: mie=%h want 3", mie);
        end
        irqSrc = 16'h0002;
        csr_write(12'h304, 64'h2);
        irqSrc = '0;
        tick();
        vectors++;
        if (interruptSignal !== 16'h0002) begin
            miscompares++;
            $display("FAIL setw_grant1: irq=%h want 0002", interruptSignal);
        end
        irqSrc  = 16'h0002;
        trapAck = 1'b1;
        tick();
        irqSrc  = '0;
        trapAck = 1'b0;
        vectors++;
        if (fsm_state !== 2'd2 || mip !== 64'h0002) begin
            miscompares++;
            $display("FAIL setw_ack: state=%0d mip=%h want 2 0002", fsm_state, mip);
        end
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;
        mret    = 1'b1;
        tick();
        mret = 1'b0;
        vectors++;
        if (mip !== 64'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL setw_drain: mip=%h busy=%b want 0 0", mip, busy);
        end
    endtask

    task automatic test_reset_midflight();
        csr_write(12'h304, 64'hFFFF);
        irqSrc = 16'h0080;
        tick();
        irqSrc = '0;
        tick();
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;
        vectors++;
        if (fsm_state !== 2'd2) begin
            miscompares++;
            $display("FAIL rstmid_service: state=%0d want 2", fsm_state);
        end
        reset           = 1'b0;
        irqSrc          = 16'h0002;
        CSR_addr        = 12'h304;
        CSR_In          = 64'hFF;
        CSR_WriteEnable = 1'b1;
        tick();
        CSR_WriteEnable = 1'b0;
        vectors++;
        if (interruptSignal !== 16'h0 || async !== 1'b0 || busy !== 1'b0 || mip !== 64'h0 || mie !== 64'h0) begin
            miscompares++;
            $display("FAIL rstmid_clear: irq=%h async=%b busy=%b mip=%h mie=%h want all 0",
                     interruptSignal, async, busy, mip, mie);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (mip !== 64'h0002) begin
            miscompares++;
            $display("FAIL rstmid_edge: mip=%h want 0002", mip);
        end
        tick();
        vectors++;
        if (mip !== 64'h0002 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_once: mip=%h busy=%b want 0002 0", mip, busy);
        end
        irqSrc = '0;
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b0;
        MIE             = 1'b0;
        irqSrc          = '0;
        syncExcept      = 1'b0;
        trapAck         = 1'b0;
        mret            = 1'b0;
        CSR_addr        = 12'h0;
        CSR_In          = '0;
        CSR_WriteEnable = 1'b0;

        test_reset();
        test_basic();
        test_priority();
        test_no_rearb();
        test_sync_abort();
        test_ignored();
        test_set_wins();
        test_reset_midflight();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter N, default 64, shall set the CSR datapath width.
REQ-002 Parameter NSRC, default 16, shall set the number of interrupt sources (1..16).
REQ-003 clk  in  1  shall be the single clock; all state updates on rising edge.
REQ-004 reset  in  1  shall be the synchronous, active-low reset.
REQ-005 MIE  in  1  shall be the global machine interrupt enable.
REQ-006 irqSrc  in  NSRC  shall carry level interrupt lines, already synchronous to clk.
REQ-007 syncExcept  in  1  shall flag a synchronous exception present this cycle.
REQ-008 trapAck  in  1  shall pulse when the pipeline has taken the presented trap.
REQ-009 mret  in  1  shall pulse when the handler executes mret.
REQ-010 CSR_addr  in  12  shall be the CSR address.
REQ-011 CSR_In  in  N  shall be the CSR write data.
REQ-012 CSR_WriteEnable  in  1  shall qualify CSR writes.
REQ-013 interruptSignal  out  16  shall be the one-hot granted source toward the exception controller; bits at and above NSRC are 0.
REQ-014 async  out  1  shall mark interruptSignal as valid asynchronous cause.
REQ-015 mip  out  N  shall be {zeros, pending[NSRC-1:0]}.
REQ-016 mie  out  N  shall be {zeros, enable[NSRC-1:0]}.
REQ-017 busy  out  1  shall be high whenever state is not IDLE.

Function
REQ-018 irqPrev register shall hold irqSrc from the previous cycle; rising edge = irqSrc & ~irqPrev.
REQ-019 A rising edge sampled at edge k shall set pending[i] after edge k.
REQ-020 CSR write to 0x304 shall load enable <= CSR_In[NSRC-1:0]; upper CSR_In bits ignored.
REQ-021 CSR write to 0x344 shall perform pending <= pending & CSR_In[NSRC-1:0] (write-0-to-clear, write-1 no effect).
REQ-022 Same-cycle set (edge) and clear (CSR write or ack) on one bit: set shall win.
REQ-023 eligible = pending & enable; priority shall be fixed, highest index wins.
REQ-024 FSM states shall be IDLE, REQ, SERVICE.
REQ-025 IDLE -> REQ when MIE & |eligible & ~syncExcept; grantIdx shall latch the winning index on that edge.
REQ-026 In REQ, interruptSignal shall equal onehot(grantIdx) and async shall be 1, both registered; all other states drive 0.
REQ-027 grantIdx shall stay fixed in REQ; a later higher-priority source shall not re-arbitrate.
REQ-028 REQ -> SERVICE on trapAck; pending[grantIdx] shall clear on the same edge (subject to REQ-022).
REQ-029 REQ -> IDLE if syncExcept or ~MIE while trapAck low; pending shall be unchanged.
REQ-030 trapAck and syncExcept together in REQ: trapAck shall win (-> SERVICE).
REQ-031 SERVICE -> IDLE on mret; no nesting, new eligible sources wait in pending.
REQ-032 trapAck outside REQ and mret outside SERVICE shall be ignored.
REQ-033 Latency: edge sampled at edge k shall produce interruptSignal/async high after edge k+1 when IDLE, MIE=1, enable set, no syncExcept.

Reset
REQ-034 On edge with reset=0: state=IDLE, pending=0, enable=0, irqPrev=0, grantIdx=0, interruptSignal=0, async=0, busy=0, mip=0, mie=0.
REQ-035 Reset shall override any in-flight REQ/SERVICE and any same-cycle CSR write.
REQ-036 A source held high through reset release shall register one edge on the first active cycle.

Verification
REQ-037 enable=0x0001, MIE=1, pulse irqSrc[0] -> interruptSignal=0x0001, async=1 two cycles later; trapAck -> SERVICE, mip=0; mret -> IDLE.
REQ-038 enable=0xFFFF, edges on bits 3 and 9 same cycle -> grant 0x0200; after mret -> grant 0x0008.
REQ-039 In REQ granting bit 2, edge on bit 15 -> interruptSignal stays 0x0004 until trapAck.
REQ-040 In REQ, syncExcept=1, trapAck=0 -> IDLE next cycle, mip unchanged, interruptSignal=0.
REQ-041 pending=0x0030, write 0x344 with 0xFFEF while edge on bit 4 -> mip=0x0030.
REQ-042 reset=0 asserted in SERVICE -> all outputs 0 next cycle; irqSrc[1] held high at release -> pending[1]=1.
